// File: rtl/sr_rf_pkg.sv
// Shared types and helpers for the sr_register_file_mp register file.
package sr_rf_pkg;

    typedef enum logic {RF_INIT, RF_READY} rf_state_t;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sr_rf_scoreboard.sv
// Per-register busy scoreboard: writes clear pending bits, sb_set marks a new producer.
module sr_rf_scoreboard
    import sr_rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 3,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = rf_aw(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NWR-1:0]          we,
    input  logic [NWR-1:0][AW-1:0]  wa,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_addr,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    output logic [NRD-1:0]          rd_busy
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Set is applied after the clears so a same-cycle set/write keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (en) begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j]) busy_d[wa[j]] = 1'b0;
            end
            if (sb_set) busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        for (int i = 0; i < int'(NRD); i++) begin
            rd_busy[i] = en & busy_q[rd_addr[i]];
        end
    end

endmodule

// File: rtl/sr_register_file_mp.sv
// Multi-port register file with sequential zero-init and busy scoreboard.
// Same-cycle write-to-read forwarding is enabled by defining SR_RF_BYPASS_EN.
module sr_register_file_mp
    import sr_rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 3,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = rf_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   wa,
    input  logic [NWR-1:0][XLEN-1:0] wd,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr
);

    rf_state_t         state_q;
    logic [AW-1:0]     ptr_q;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NRD-1:0]    sb_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RF_INIT;
            ptr_q     <= AW'(1);
            init_done <= 1'b0;
        end else begin
            unique case (state_q)
                RF_INIT: begin
                    if (ptr_q == AW'(NREGS - 1)) begin
                        state_q   <= RF_READY;
                        init_done <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                RF_READY: ;
                default:  state_q <= RF_INIT;
            endcase
        end
    end

    // Array has no reset; INIT sweeps it to zero. Later ports override earlier ones.
    always_ff @(posedge clk) begin
        if (state_q == RF_INIT) begin
            regs[ptr_q] <= '0;
        end else begin
            for (int j = 0; j < int'(NWR); j++) begin
                if (we[j] && wa[j] != '0) regs[wa[j]] <= wd[j];
            end
        end
    end

    sr_rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .en      (init_done),
        .we      (we),
        .wa      (wa),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .rd_addr (rd_addr),
        .rd_busy (sb_busy)
    );

    always_comb begin
        for (int i = 0; i < int'(NRD); i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if (init_done && rd_addr[i] != '0) begin
                rd_data[i] = regs[rd_addr[i]];
                rd_busy[i] = sb_busy[i];
`ifdef SR_RF_BYPASS_EN
                for (int j = 0; j < int'(NWR); j++) begin
                    if (we[j] && wa[j] == rd_addr[i]) begin
                        rd_data[i] = wd[j];
                        rd_busy[i] = sb_set && (sb_addr == rd_addr[i]);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sr_register_file_mp.sv
// Directed self-checking bench for sr_register_file_mp (default parameters).
module tb_sr_register_file_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                  clk;
    logic                  rst;
    logic                  init_done;
    logic [2:0][AW-1:0]    rd_addr;
    logic [2:0][XLEN-1:0]  rd_data;
    logic [2:0]            rd_busy;
    logic [1:0]            we;
    logic [1:0][AW-1:0]    wa;
    logic [1:0][XLEN-1:0]  wd;
    logic                  sb_set;
    logic [AW-1:0]         sb_addr;

    int nchecks = 0;
    int nerr    = 0;

    sr_register_file_mp dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we      = '0;
        wa      = '0;
        wd      = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    // Called right after rst is released (between edges): expects 30 low edges then high.
    task automatic wait_init(input string tag);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk({tag, "_low"}, {31'b0, init_done}, 32'd0);
        end
        step();
        chk({tag, "_high"}, {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        step();
        step();
        chk("reset_init_done", {31'b0, init_done}, 32'd0);
        rd_addr[0] = 5'd1;
        rd_addr[1] = 5'd31;
        #1;
        chk("reset_rd0", rd_data[0], 32'd0);
        chk("reset_busy", {29'b0, rd_busy}, 32'd0);

        // Test 1: release reset, 31 edges to ready, array cleared.
        rst = 1'b0;
        wait_init("init1");
        rd_addr[0] = 5'd1;
        rd_addr[1] = 5'd17;
        rd_addr[2] = 5'd31;
        #1;
        chk("clr_r1", rd_data[0], 32'd0);
        chk("clr_r17", rd_data[1], 32'd0);
        chk("clr_r31", rd_data[2], 32'd0);

        // Test 2: single write, visible next cycle; reg 0 stays zero.
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        rd_addr[0] = 5'd5;
        #1;
        chk("r5_same_cycle", rd_data[0], 32'hDEAD_BEEF
`ifndef SR_RF_BYPASS_EN
            & 32'h0
`endif
        );
        step();
        idle();
        #1;
        chk("r5_written", rd_data[0], 32'hDEAD_BEEF);
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
        step();
        idle();
        rd_addr[1] = 5'd0;
        #1;
        chk("r0_zero", rd_data[1], 32'd0);

        // Test 3: both ports to reg 7, port 1 wins; distinct addresses both land.
        we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'd1; wd[1] = 32'd2;
        step();
        we = 2'b11; wa[0] = 5'd10; wa[1] = 5'd11; wd[0] = 32'hA0; wd[1] = 32'hB1;
        step();
        idle();
        rd_addr[0] = 5'd7; rd_addr[1] = 5'd10; rd_addr[2] = 5'd11;
        #1;
        chk("r7_prio", rd_data[0], 32'd2);
        chk("r10", rd_data[1], 32'hA0);
        chk("r11", rd_data[2], 32'hB1);

        // Test 4: scoreboard set/clear/priority.
        rd_addr[1] = 5'd9; rd_addr[2] = 5'd0;
        sb_set = 1'b1; sb_addr = 5'd9;
        step();
        idle();
        #1;
        chk("busy9_set", {31'b0, rd_busy[1]}, 32'd1);
        sb_set = 1'b1; sb_addr = 5'd0;
        step();
        idle();
        #1;
        chk("busy0_ignored", {31'b0, rd_busy[2]}, 32'd0);
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h55;
        step();
        idle();
        #1;
        chk("busy9_clear", {31'b0, rd_busy[1]}, 32'd0);
        chk("r9_data", rd_data[1], 32'h55);
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h99; sb_set = 1'b1; sb_addr = 5'd9;
        step();
        idle();
        #1;
        chk("busy9_set_wins", {31'b0, rd_busy[1]}, 32'd1);
        chk("r9_data2", rd_data[1], 32'h99);
        sb_set = 1'b1; sb_addr = 5'd9;
        step();
        idle();
        #1;
        chk("busy9_reset_stays", {31'b0, rd_busy[1]}, 32'd1);

        // Test 6: same-cycle read/write of reg 3 while it is busy.
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h11;
        sb_set = 1'b0;
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd3;
        step();
        idle();
        rd_addr[0] = 5'd3;
        we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h1234;
        #1;
`ifdef SR_RF_BYPASS_EN
        chk("r3_bypass_data", rd_data[0], 32'h1234);
        chk("r3_bypass_busy", {31'b0, rd_busy[0]}, 32'd0);
`else
        chk("r3_old_data", rd_data[0], 32'h11);
        chk("r3_old_busy", {31'b0, rd_busy[0]}, 32'd1);
`endif
        step();
        idle();
        #1;
        chk("r3_after", rd_data[0], 32'h1234);
        chk("r3_busy_after", {31'b0, rd_busy[0]}, 32'd0);

        // Test 5a: reset during READY (asynchronous), re-clear wipes data and busy.
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd9; rd_addr[2] = 5'd7;
        rst = 1'b1;
        #1;
        chk("rst_ready_low", {31'b0, init_done}, 32'd0);
        chk("rst_ready_gated", rd_data[0], 32'd0);
        step();
        rst = 1'b0;
        wait_init("init2");
        #1;
        chk("reclr_r5", rd_data[0], 32'd0);
        chk("reclr_r7", rd_data[2], 32'd0);
        chk("reclr_busy9", {31'b0, rd_busy[1]}, 32'd0);

        // Test 5b: reset mid-INIT at ptr = 12; writes/sets during INIT are dropped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 11; k++) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_low", {31'b0, init_done}, 32'd0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("init3_low", {31'b0, init_done}, 32'd0);
        end
        we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'hBAD;
        sb_set = 1'b1; sb_addr = 5'd4;
        rd_addr[0] = 5'd2;
        #1;
        chk("init_rd_gated", rd_data[0], 32'd0);
        for (int k = 11; k <= 30; k++) begin
            step();
            idle();
            chk("init3_low", {31'b0, init_done}, 32'd0);
        end
        step();
        chk("init3_high", {31'b0, init_done}, 32'd1);
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd4;
        #1;
        chk("init_write_dropped", rd_data[0], 32'd0);
        chk("init_sbset_dropped", {31'b0, rd_busy[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
